// File: rtl/vector_issue_sequencer_if.sv
// vector_issue_sequencer_if: issue handshake, stall input and register-file controls of the sequencer
interface vector_issue_sequencer_if #(
   parameter int VL_W = 6
);
   logic            issue_valid;
   logic            issue_ready;
   logic [4:0]      i_vs1;
   logic [4:0]      i_vs2;
   logic [4:0]      i_vd;
   logic [VL_W-1:0] i_vl;
   logic [1:0]      i_vsew;
   logic            i_widening;
   logic            i_wb;
   logic            pe_stall;
   logic [4:0]      vs1_addr;
   logic [4:0]      vs2_addr;
   logic [4:0]      vd_addr;
   logic [1:0]      vsew;
   logic            widening_op;
   logic [1:0]      elements_to_write;
   logic            write;
   logic            busy;
   logic            done;
   logic            err;
   modport master (
      output issue_valid, i_vs1, i_vs2, i_vd, i_vl, i_vsew, i_widening, i_wb, pe_stall,
      input  issue_ready, vs1_addr, vs2_addr, vd_addr, vsew, widening_op,
             elements_to_write, write, busy, done, err
   );
   modport slave (
      input  issue_valid, i_vs1, i_vs2, i_vd, i_vl, i_vsew, i_widening, i_wb, pe_stall,
      output issue_ready, vs1_addr, vs2_addr, vd_addr, vsew, widening_op,
             elements_to_write, write, busy, done, err
   );
endinterface

// File: rtl/vector_issue_sequencer.sv
// vector_issue_sequencer: walks one vector instruction across its register group, 4 elements per step
module vector_issue_sequencer #(
   parameter int VL_W = 6
) (
   input logic                     clk,
   input logic                     n_reset,
   vector_issue_sequencer_if.slave bus
);
   localparam int ELEMS_PER_STEP = 4;
   localparam logic [VL_W-1:0] STEP = VL_W'(ELEMS_PER_STEP);
   typedef enum logic {IDLE, RUN} state_t;
   state_t          state_q;
   logic [4:0]      vs1_q, vs2_q, vd_q;
   logic [1:0]      vsew_q;
   logic            wid_q, wb_q, done_q, err_q;
   logic [VL_W-1:0] rem_q;
   logic [4:0]      s_stride, d_stride;
   logic            illegal, last, step;
   assign s_stride = 5'd1 << vsew_q;
   assign d_stride = s_stride << wid_q;
   assign illegal  = bus.i_vsew == 2'd3 || (bus.i_widening && bus.i_vsew == 2'd2);
   assign last     = rem_q <= STEP;
   assign step     = state_q == RUN && !bus.pe_stall;
   assign bus.issue_ready       = state_q == IDLE;
   assign bus.busy              = state_q == RUN;
   assign bus.vs1_addr          = vs1_q;
   assign bus.vs2_addr          = vs2_q;
   assign bus.vd_addr           = vd_q;
   assign bus.vsew              = vsew_q;
   assign bus.widening_op       = wid_q;
   assign bus.elements_to_write = rem_q >= STEP ? 2'd0 : rem_q[1:0];
   assign bus.write             = step && wb_q;
   assign bus.done              = done_q;
   assign bus.err               = err_q;
   // accept/reject instructions in IDLE, advance one step per unstalled RUN cycle;
   // remaining is left untouched on the last step so elements_to_write holds in IDLE
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vd_q    <= '0;
         vsew_q  <= '0;
         wid_q   <= 1'b0;
         wb_q    <= 1'b0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.issue_valid) begin
               if (illegal) err_q <= 1'b1;
               else if (bus.i_vl == '0) done_q <= 1'b1;
               else begin
                  vs1_q   <= bus.i_vs1;
                  vs2_q   <= bus.i_vs2;
                  vd_q    <= bus.i_vd;
                  vsew_q  <= bus.i_vsew;
                  wid_q   <= bus.i_widening;
                  wb_q    <= bus.i_wb;
                  rem_q   <= bus.i_vl;
                  state_q <= RUN;
               end
            end
            RUN: if (!bus.pe_stall) begin
               vs1_q <= vs1_q + s_stride;
               vs2_q <= vs2_q + s_stride;
               vd_q  <= vd_q + d_stride;
               if (last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else rem_q <= rem_q - STEP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vector_issue_sequencer.sv
// tb_vector_issue_sequencer: randomized and directed checks of the sequencer against a step-list model
module tb_vector_issue_sequencer;
   typedef struct {
      logic [4:0] vs1, vs2, vd;
      int         vl;
      logic [1:0] vsew;
      logic       wid, wb;
   } instr_t;
   logic clk, n_reset;
   int vectors = 0, miscompares = 0;
   vector_issue_sequencer_if #(.VL_W(6)) bus ();
   vector_issue_sequencer #(.VL_W(6)) dut (.clk(clk), .n_reset(n_reset), .bus(bus.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic drive(input instr_t t);
      bus.i_vs1 = t.vs1;
      bus.i_vs2 = t.vs2;
      bus.i_vd = t.vd;
      bus.i_vl = 6'(t.vl);
      bus.i_vsew = t.vsew;
      bus.i_widening = t.wid;
      bus.i_wb = t.wb;
      bus.issue_valid = 1'b1;
   endtask
   task automatic test_reset();
      logic [24:0] act;
      n_reset = 1'b0;
      #1;
      act = {bus.vs1_addr, bus.vs2_addr, bus.vd_addr, bus.vsew, bus.widening_op, bus.elements_to_write,
             bus.write, bus.busy, bus.done, bus.err, bus.issue_ready};
      vectors++;
      if (act !== 25'd1) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected %h", act, 25'd1);
      end
      @(negedge clk);
      n_reset = 1'b1;
   endtask
   task automatic test_sequencing();
      instr_t q[$];
      instr_t t;
      int n, s, d, k, cyc, rem;
      logic stall;
      logic [23:0] act, exp;
      q.push_back('{5'd1, 5'd2, 5'd3, 4, 2'd0, 1'b0, 1'b1});
      q.push_back('{5'd8, 5'd16, 5'd24, 10, 2'd1, 1'b0, 1'b1});
      q.push_back('{5'd4, 5'd5, 5'd8, 7, 2'd0, 1'b1, 1'b1});
      repeat (30) begin
         t.vs1 = 5'($urandom);
         t.vs2 = 5'($urandom);
         t.vd = 5'($urandom);
         t.vl = int'($urandom_range(32, 1));
         t.vsew = 2'($urandom_range(2));
         t.wid = t.vsew != 2'd2 && $urandom_range(1) == 1;
         t.wb = $urandom_range(3) != 0;
         q.push_back(t);
      end
      foreach (q[i]) begin
         t = q[i];
         n = (t.vl + 3) / 4;
         s = 1 << t.vsew;
         d = s << t.wid;
         k = 0;
         cyc = 0;
         @(negedge clk);
         drive(t);
         #1;
         vectors++;
         if ({bus.issue_ready, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL seq_idle[%0d]: ready/busy got %b expected 10", i, {bus.issue_ready, bus.busy});
         end
         while (k < n && cyc < n * 8 + 8) begin
            @(negedge clk);
            bus.issue_valid = 1'b0;
            stall = i >= 3 && $urandom_range(3) == 0;
            bus.pe_stall = stall;
            #1;
            rem = t.vl - 4 * k;
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 5'((t.vs1 + k * s) % 32), 5'((t.vs2 + k * s) % 32),
                   5'((t.vd + k * d) % 32), t.vsew, t.wid, 2'(rem >= 4 ? 0 : rem), t.wb && !stall};
            act = {bus.busy, bus.issue_ready, bus.done, bus.err, bus.vs1_addr, bus.vs2_addr, bus.vd_addr,
                   bus.vsew, bus.widening_op, bus.elements_to_write, bus.write};
            vectors++;
            if (act !== exp) begin
               miscompares++;
               $display("FAIL seq_step[%0d] k=%0d stall=%0b: got %h expected %h", i, k, stall, act, exp);
            end
            if (!stall) k++;
            cyc++;
         end
         if (k < n) begin
            miscompares++;
            $display("FAIL seq_timeout[%0d]: %0d of %0d steps seen", i, k, n);
         end
         @(negedge clk);
         bus.pe_stall = 1'b0;
         #1;
         vectors++;
         if ({bus.done, bus.err, bus.busy, bus.write, bus.issue_ready} !== 5'b10001) begin
            miscompares++;
            $display("FAIL seq_done[%0d]: got %b expected 10001", i,
                     {bus.done, bus.err, bus.busy, bus.write, bus.issue_ready});
         end
      end
   endtask
   task automatic test_stall();
      instr_t t = '{5'd0, 5'd4, 5'd28, 8, 2'd2, 1'b0, 1'b1};
      logic stalls [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [4:0] e_vs1 [4] = '{5'd0, 5'd0, 5'd0, 5'd4};
      logic [4:0] e_vd [4] = '{5'd28, 5'd28, 5'd28, 5'd0};
      logic [13:0] act, exp;
      @(negedge clk);
      drive(t);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.issue_valid = 1'b0;
         bus.pe_stall = stalls[c];
         #1;
         exp = {1'b1, 1'b0, e_vs1[c], e_vd[c], 2'd0, !stalls[c]};
         act = {bus.busy, bus.done, bus.vs1_addr, bus.vd_addr, bus.elements_to_write, bus.write};
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL stall_cycle%0d: got %h expected %h", c, act, exp);
         end
      end
      @(negedge clk);
      bus.pe_stall = 1'b0;
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.write} !== 3'b010) begin
         miscompares++;
         $display("FAIL stall_done: busy/done/write got %b expected 010", {bus.busy, bus.done, bus.write});
      end
   endtask
   task automatic test_illegal_zero();
      instr_t t [3] = '{'{5'd1, 5'd2, 5'd3, 0, 2'd0, 1'b0, 1'b1},
                        '{5'd1, 5'd2, 5'd3, 5, 2'd3, 1'b0, 1'b1},
                        '{5'd1, 5'd2, 5'd3, 5, 2'd2, 1'b1, 1'b1}};
      logic [1:0] e_de [3] = '{2'b10, 2'b01, 2'b01};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(t[i]);
         @(negedge clk);
         bus.issue_valid = 1'b0;
         #1;
         vectors++;
         if ({bus.done, bus.err, bus.write, bus.busy, bus.issue_ready} !== {e_de[i], 3'b001}) begin
            miscompares++;
            $display("FAIL pulse[%0d]: done/err/write/busy/ready got %b expected %b", i,
                     {bus.done, bus.err, bus.write, bus.busy, bus.issue_ready}, {e_de[i], 3'b001});
         end
         @(negedge clk);
         #1;
         vectors++;
         if ({bus.done, bus.err, bus.write, bus.busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL pulse_len[%0d]: done/err/write/busy got %b expected 0000", i,
                     {bus.done, bus.err, bus.write, bus.busy});
         end
      end
   endtask
   task automatic test_reset_mid();
      logic [24:0] act;
      @(negedge clk);
      drive('{5'd3, 5'd5, 5'd7, 16, 2'd0, 1'b0, 1'b1});
      @(negedge clk);
      bus.issue_valid = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.vs1_addr, bus.busy} !== {5'd4, 1'b1}) begin
         miscompares++;
         $display("FAIL rst_mid_step1: vs1/busy got %h expected %h", {bus.vs1_addr, bus.busy}, {5'd4, 1'b1});
      end
      n_reset = 1'b0;
      #1;
      act = {bus.vs1_addr, bus.vs2_addr, bus.vd_addr, bus.vsew, bus.widening_op, bus.elements_to_write,
             bus.write, bus.busy, bus.done, bus.err, bus.issue_ready};
      vectors++;
      if (act !== 25'd1) begin
         miscompares++;
         $display("FAIL rst_mid_outputs: got %h expected %h", act, 25'd1);
      end
      @(negedge clk);
      n_reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         #1;
         vectors++;
         if ({bus.done, bus.err, bus.busy, bus.issue_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_mid_after: done/err/busy/ready got %b expected 0001",
                     {bus.done, bus.err, bus.busy, bus.issue_ready});
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [18:0] act, exp;
      @(negedge clk);
      drive('{5'd1, 5'd2, 5'd3, 4, 2'd0, 1'b0, 1'b1});
      @(negedge clk);
      bus.issue_valid = 1'b0;
      @(negedge clk);
      drive('{5'd10, 5'd12, 5'd20, 8, 2'd1, 1'b1, 1'b0});
      #1;
      vectors++;
      if ({bus.done, bus.issue_ready} !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_done: done/ready got %b expected 11", {bus.done, bus.issue_ready});
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus.issue_valid = 1'b0;
         #1;
         exp = {1'b1, 5'(10 + 2 * k), 5'(12 + 2 * k), 5'(20 + 4 * k), 1'b1, 2'd0};
         act = {bus.busy, bus.vs1_addr, bus.vs2_addr, bus.vd_addr, bus.widening_op, bus.write, bus.done};
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL b2b_step%0d: got %h expected %h", k, act, exp);
         end
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.done, bus.busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_end: done/busy got %b expected 10", {bus.done, bus.busy});
      end
   endtask
   initial begin
      bus.issue_valid = 1'b0;
      bus.pe_stall = 1'b0;
      bus.i_vs1 = '0;
      bus.i_vs2 = '0;
      bus.i_vd = '0;
      bus.i_vl = '0;
      bus.i_vsew = '0;
      bus.i_widening = 1'b0;
      bus.i_wb = 1'b0;
      test_reset();
      test_sequencing();
      test_stall();
      test_illegal_zero();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
- Sits directly upstream of vector_registers. Accepts one decoded vector instruction at a time and walks it across its register group in 4-element steps.
- Each step drives the register file's read and write addresses, SEW/widening controls, elements_to_write and write.
- Register-file read, PE compute and write-back complete in one step. pe_stall holds the current step when the PEs need more cycles.

Parameters:
VL_W, 6, width of vl; max vl = 32 (8b elements, LMUL=8, VLEN=32).
ELEMS_PER_STEP, 4, elements processed per step (number of PEs); fixed, not overridable.

Ports:
clk  input  1  clock
n_reset  input  1  reset, asynchronous, active-low
issue_valid  input  1  instruction fields valid
issue_ready  output  1  sequencer can accept an instruction
i_vs1  input  5  vs1 base register
i_vs2  input  5  vs2 base register
i_vd  input  5  vd/vs3 base register
i_vl  input  VL_W  element count
i_vsew  input  2  0=8b, 1=16b, 2=32b
i_widening  input  1  widening op (vd EEW = 2*SEW)
i_wb  input  1  instruction writes vd
pe_stall  input  1  hold current step
vs1_addr  output  5  to register file
vs2_addr  output  5  to register file
vd_addr  output  5  to register file
vsew  output  2  to register file
widening_op  output  1  to register file
elements_to_write  output  2  0 = all 4; 1..3 = partial count
write  output  1  write strobe to register file
busy  output  1  instruction in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal-instruction pulse

Behaviour:
- States: IDLE, RUN.
- Reset: state=IDLE, all address outputs 0, vsew=0, widening_op=0, elements_to_write=0, write=0, busy=0, done=0, err=0, remaining counter 0, wb flag 0.
- issue_ready = (state==IDLE). An instruction is accepted at the rising edge where issue_valid & issue_ready.
- Illegal instruction: i_vsew==3, or i_widening with i_vsew==2.
  - Stay IDLE; err=1 for the next cycle; done=0; no write.
- Zero-length instruction: legal with i_vl==0.
  - Stay IDLE; done=1 for the next cycle; no write.
- Accept, otherwise:
  - Register the base addresses, vsew, widening_op and wb flag; remaining = i_vl.
  - state -> RUN; busy=1 from the next cycle.
- Source stride S = 1/2/4 registers for vsew 0/1/2.
- Destination stride D = S, or 2*S when widening. Widening with vsew 8b gives D=2; with 16b gives D=4.
- Address arithmetic is modulo 32 (5-bit wrap). Base alignment is software's responsibility; no check.
- In RUN:
  - elements_to_write = (remaining>=4) ? 0 : remaining[1:0].
  - write = wb & ~pe_stall. This is combinational from registered state, so the register file writes at the end of the step cycle.
- At each RUN edge with pe_stall=0:
  - vs1_addr += S, vs2_addr += S, vd_addr += D, remaining -= 4.
  - If remaining <= 4 before the decrement, this is the last step: state -> IDLE, done=1 for the next cycle, busy=0.
- pe_stall=1 in RUN: all outputs held, write=0, counter frozen. Stall in IDLE is ignored.
- Step count is ceil(vl/4); an instruction occupies ceil(vl/4) + stalled cycles.
- done and issue_ready are both high in the cycle after the last step. A new instruction may be accepted in that same cycle (back-to-back, no bubble beyond one IDLE cycle).
- vd_addr stays valid throughout RUN because the register file reads vs3 from it.
- Outputs hold their last values in IDLE; write is always 0 in IDLE.
- vd=v0 is still sequenced; the register file suppresses the write.
- Reset asserted mid-instruction: immediate return to reset values. The instruction is dropped and neither done nor err is pulsed.

Test Plan:
- vsew=0, vl=4, vs1=1, vs2=2, vd=3, wb=1 -> 1 RUN cycle: addrs 1/2/3, elements_to_write=0, write=1; done next cycle.
- vsew=1, vl=10, vs1=8, vs2=16, vd=24 -> 3 steps: (8,16,24,etw0), (10,18,26,etw0), (12,20,28,etw2); done after step 3.
- vsew=0, widening=1, vl=7, vs1=4, vs2=5, vd=8 -> 2 steps: (4,5,8,etw0), (5,6,10,etw3); widening_op=1 throughout.
- vsew=2, vl=8, vd=28, pe_stall high for 2 cycles on step 0 -> step 0 held 3 cycles with write only in the last; vd 28 then 0 (wrap); busy 4 cycles total.
- vl=0 -> done pulse, no write. vsew=3 -> err pulse, no write. widening with vsew=2 -> err pulse, no write.
- Reset mid-RUN at step 1 of a vl=16 op -> all outputs 0, issue_ready=1, no done. Back-to-back issue asserted on the done cycle -> accepted, new RUN next cycle.
